tile_fetch_sched: RTL and testbench

- Time-shares one synchronous tile character ROM (24-bit data, 3 planes) between the two BG scanline generators (requester 0 and requester 1).
- Sits between both BG generators and the tile ROM, in the 8x pixel clock domain. It replaces fixed HPOS-phase address muxing with request/return handshakes.
- Round-robin arbitration; per-requester data hold registers.
- Per-tile deadline monitoring, with saturating miss counters for debug and verification.

---
 rtl/tile_fetch_sched.sv | 136 +++++++++++++
 tb/tb_tile_fetch_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_fetch_sched.sv
// Round-robin scheduler that shares one synchronous tile ROM between two BG scanline
// generators, with per-requester data hold registers and saturating deadline-miss counters.
//   state | meaning
//   IDLE  | no fetch in flight, arbitrate pending requests
//   RD    | rom_ad stable, waiting out ROM latency
//   CAP   | ROM data valid, latch into the selected hold register
module tile_fetch_sched #(
  parameter int AW      = 15,
  parameter int DW      = 24,
  parameter int ROM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          PCLK_EN,
  input  logic [2:0]    HPHASE,
  input  logic          req0,
  input  logic [AW-1:0] ad0,
  input  logic          req1,
  input  logic [AW-1:0] ad1,
  output logic [AW-1:0] rom_ad,
  input  logic [DW-1:0] rom_dt,
  output logic [DW-1:0] dt0,
  output logic [DW-1:0] dt1,
  output logic          vld0,
  output logic          vld1,
  output logic          busy,
  input  logic          miss_clr,
  output logic [7:0]    miss0,
  output logic [7:0]    miss1
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP} state_t;

  localparam logic [1:0] CNT_INIT = 2'(ROM_LAT - 1);

  state_t     state, state_nxt;
  logic       pend0, pend1;
  logic       req0_d, req1_d;
  logic       last, sel;
  logic [1:0] cnt;
  logic       grant, grant_sel, cap;
  logic       rise0, rise1;
  logic       deadline, late0, late1;

  assign rise0    = req0 & ~req0_d;
  assign rise1    = req1 & ~req1_d;
  assign busy     = (state != S_IDLE);
  assign deadline = PCLK_EN && (HPHASE == 3'd7);
  assign late0    = pend0 | (busy & ~sel);
  assign late1    = pend1 | (busy & sel);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = 1'b0;
    cap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend0 || pend1) begin
          grant     = 1'b1;
          grant_sel = (pend0 && pend1) ? ~last : pend1;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (cnt == 2'd0) state_nxt = S_CAP;
      end
      S_CAP: begin
        cap       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rom_ad <= '0;
      dt0    <= '0;
      dt1    <= '0;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
      pend0  <= 1'b0;
      pend1  <= 1'b0;
      req0_d <= 1'b0;
      req1_d <= 1'b0;
      last   <= 1'b1;
      sel    <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      req0_d <= req0;
      req1_d <= req1;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
      if (grant) begin
        rom_ad <= grant_sel ? ad1 : ad0;
        sel    <= grant_sel;
        last   <= grant_sel;
        cnt    <= CNT_INIT;
      end else if (state == S_RD && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
      if (cap) begin
        if (sel) begin
          dt1  <= rom_dt;
          vld1 <= 1'b1;
        end else begin
          dt0  <= rom_dt;
          vld0 <= 1'b1;
        end
      end
      // a rising edge in the CAP cycle keeps the requester pending
      pend0 <= rise0 | (pend0 & ~(cap & ~sel));
      pend1 <= rise1 | (pend1 & ~(cap & sel));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      miss0 <= 8'd0;
      miss1 <= 8'd0;
    end else if (miss_clr) begin
      miss0 <= 8'd0;
      miss1 <= 8'd0;
    end else if (deadline) begin
      if (late0 && miss0 != 8'hFF) miss0 <= miss0 + 8'd1;
      if (late1 && miss1 != 8'hFF) miss1 <= miss1 + 8'd1;
    end
  end

endmodule

// File: tb/tb_tile_fetch_sched.sv
// Directed bench: instance a uses ROM_LAT=1, instance b uses ROM_LAT=4; both share stimulus.
module tb_tile_fetch_sched;

  localparam int AW = 15;
  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          PCLK_EN;
  logic [2:0]    HPHASE;
  logic          req0, req1, miss_clr;
  logic [AW-1:0] ad0, ad1;

  logic [AW-1:0] a_rom_ad, b_rom_ad;
  logic [DW-1:0] a_rom_dt, b_rom_dt;
  logic [DW-1:0] a_dt0, a_dt1, b_dt0, b_dt1;
  logic          a_vld0, a_vld1, a_busy, b_vld0, b_vld1, b_busy;
  logic [7:0]    a_miss0, a_miss1, b_miss0, b_miss1;
  logic [DW-1:0] b_pipe [4];

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  tile_fetch_sched #(.AW(AW), .DW(DW), .ROM_LAT(1)) u_a (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HPHASE(HPHASE),
    .req0(req0), .ad0(ad0), .req1(req1), .ad1(ad1),
    .rom_ad(a_rom_ad), .rom_dt(a_rom_dt), .dt0(a_dt0), .dt1(a_dt1),
    .vld0(a_vld0), .vld1(a_vld1), .busy(a_busy), .miss_clr(miss_clr),
    .miss0(a_miss0), .miss1(a_miss1)
  );

  tile_fetch_sched #(.AW(AW), .DW(DW), .ROM_LAT(4)) u_b (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .HPHASE(HPHASE),
    .req0(req0), .ad0(ad0), .req1(req1), .ad1(ad1),
    .rom_ad(b_rom_ad), .rom_dt(b_rom_dt), .dt0(b_dt0), .dt1(b_dt1),
    .vld0(b_vld0), .vld1(b_vld1), .busy(b_busy), .miss_clr(miss_clr),
    .miss0(b_miss0), .miss1(b_miss1)
  );

  // ROM models: data = {addr, addr[8:0]}
  always @(posedge CLK) a_rom_dt <= {a_rom_ad, a_rom_ad[8:0]};

  always @(posedge CLK) begin
    b_pipe[0] <= {b_rom_ad, b_rom_ad[8:0]};
    for (int i = 1; i < 4; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign b_rom_dt = b_pipe[3];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
  endtask

  int seen_vld1, seen_busy;

  initial begin
    RESET = 1'b1; PCLK_EN = 1'b0; HPHASE = 3'd0; miss_clr = 1'b0;
    req0 = 1'b0; req1 = 1'b0; ad0 = '0; ad1 = '0;
    #1;
    chk("rst_rom_ad", 32'(a_rom_ad), 32'h0);
    chk("rst_dt0",    32'(a_dt0),    32'h0);
    chk("rst_dt1",    32'(a_dt1),    32'h0);
    chk("rst_vld",    32'({a_vld0, a_vld1, b_vld0, b_vld1}), 32'h0);
    chk("rst_busy",   32'({a_busy, b_busy}), 32'h0);
    chk("rst_miss",   32'({a_miss0, a_miss1, b_miss0, b_miss1}), 32'h0);
    step(2);
    RESET = 1'b0;
    step(1);

    // single request
    req0 = 1'b1; ad0 = 15'h1234;
    step(1);
    chk("single_idle_at_capture", 32'(a_busy), 32'h0);
    step(1);
    chk("single_busy",   32'(a_busy),   32'h1);
    chk("single_rom_ad", 32'(a_rom_ad), 32'h1234);
    step(1);
    chk("single_no_vld_early", 32'(a_vld0), 32'h0);
    step(1);
    chk("single_vld0", 32'(a_vld0), 32'h1);
    chk("single_dt0",  32'(a_dt0),  32'h246834);
    chk("single_vld1", 32'(a_vld1), 32'h0);
    req0 = 1'b0;
    step(1);
    chk("single_vld0_pulse", 32'(a_vld0), 32'h0);

    // contention after reset: BG0 first
    do_reset();
    req0 = 1'b1; ad0 = 15'h0010;
    req1 = 1'b1; ad1 = 15'h4020;
    step(2);
    chk("cont1_rom_ad0", 32'(a_rom_ad), 32'h0010);
    step(2);
    chk("cont1_vld0", 32'({a_vld0, a_vld1}), 32'h2);
    chk("cont1_dt0",  32'(a_dt0), 32'h002010);
    req0 = 1'b0;
    step(1);
    chk("cont1_rom_ad1", 32'(a_rom_ad), 32'h4020);
    step(2);
    chk("cont1_vld1", 32'({a_vld0, a_vld1}), 32'h1);
    chk("cont1_dt1",  32'(a_dt1), 32'h804020);
    chk("cont1_dt0_held", 32'(a_dt0), 32'h002010);
    req1 = 1'b0;
    step(1);

    // set/clear collision: new BG0 edge lands in CAP of the previous BG0 fetch
    req0 = 1'b1; ad0 = 15'h0155;
    step(2);
    chk("coll_rom_ad_first", 32'(a_rom_ad), 32'h0155);
    ad0 = 15'h0ABC; req0 = 1'b0;
    step(1);
    chk("coll_ad_sampled_at_grant", 32'(a_rom_ad), 32'h0155);
    req0 = 1'b1;
    step(1);
    chk("coll_vld0_first", 32'(a_vld0), 32'h1);
    chk("coll_dt0_first",  32'(a_dt0),  32'h02AB55);
    step(1);
    chk("coll_regrant_busy",   32'(a_busy),   32'h1);
    chk("coll_regrant_rom_ad", 32'(a_rom_ad), 32'h0ABC);
    step(2);
    chk("coll_vld0_second", 32'(a_vld0), 32'h1);
    chk("coll_dt0_second",  32'(a_dt0),  32'h1578BC);

    // second contended pair: BG0 was served last, so BG1 wins
    req0 = 1'b0;
    step(1);
    req0 = 1'b1; req1 = 1'b1; ad1 = 15'h7FFF;
    step(2);
    chk("cont2_rom_ad1_first", 32'(a_rom_ad), 32'h7FFF);
    step(2);
    chk("cont2_vld1", 32'({a_vld0, a_vld1}), 32'h1);
    chk("cont2_dt1",  32'(a_dt1), 32'hFFFFFF);
    ad1 = 15'h1111;
    step(1);
    chk("cont2_rom_ad0_second", 32'(a_rom_ad), 32'h0ABC);
    step(2);
    chk("cont2_vld0", 32'({a_vld0, a_vld1}), 32'h2);
    chk("cont2_dt0",  32'(a_dt0), 32'h1578BC);
    req0 = 1'b0;

    // hold: req1 stays high without a new edge
    seen_vld1 = 0; seen_busy = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (a_vld1) seen_vld1++;
      if (a_busy) seen_busy++;
    end
    chk("hold_no_vld1",  32'(seen_vld1), 32'h0);
    chk("hold_no_busy",  32'(seen_busy), 32'h0);
    chk("hold_dt1",      32'(a_dt1),     32'hFFFFFF);
    chk("hold_rom_ad",   32'(a_rom_ad),  32'h0ABC);
    req1 = 1'b0;
    step(2);

    // async reset during RD
    req0 = 1'b1; ad0 = 15'h0200;
    step(2);
    chk("arst_pre_busy", 32'(a_busy), 32'h1);
    RESET = 1'b1;
    #1;
    chk("arst_busy",   32'(a_busy),   32'h0);
    chk("arst_rom_ad", 32'(a_rom_ad), 32'h0);
    chk("arst_dt",     32'({a_dt0, a_dt1}), 32'h0);
    chk("arst_vld",    32'({a_vld0, a_vld1}), 32'h0);
    req0 = 1'b0; req1 = 1'b1; ad1 = 15'h2222;
    step(2);
    RESET = 1'b0;
    step(1);
    chk("arst_capture_idle", 32'(a_busy), 32'h0);
    step(1);
    chk("arst_grant_busy",   32'(a_busy),   32'h1);
    chk("arst_grant_rom_ad", 32'(a_rom_ad), 32'h2222);
    step(2);
    chk("arst_vld1", 32'(a_vld1), 32'h1);
    chk("arst_dt1",  32'(a_dt1),  32'h444422);
    req1 = 1'b0;
    step(2);

    // deadline monitoring on the ROM_LAT=4 instance
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    req0 = 1'b1; ad0 = 15'h0001;
    req1 = 1'b1; ad1 = 15'h0002;
    step(2);
    PCLK_EN = 1'b1; HPHASE = 3'd7;
    step(1);
    chk("dl_first_miss", 32'({b_miss0, b_miss1}), 32'h0101);
    HPHASE = 3'd6;
    step(1);
    chk("dl_wrong_phase", 32'({b_miss0, b_miss1}), 32'h0101);
    PCLK_EN = 1'b0; HPHASE = 3'd7;
    step(1);
    chk("dl_no_pclk_en", 32'({b_miss0, b_miss1}), 32'h0101);
    PCLK_EN = 1'b1;
    for (int i = 0; i < 600; i++) begin
      req0 = (i % 2 == 0);
      req1 = (i % 2 == 1);
      step(1);
    end
    chk("dl_saturate", 32'({b_miss0, b_miss1}), 32'hFFFF);
    miss_clr = 1'b1;
    step(1);
    chk("dl_clr_priority", 32'({b_miss0, b_miss1}), 32'h0);
    miss_clr = 1'b0; PCLK_EN = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
